// File: rtl/rv32i_types.sv
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared types for the cache arbiter slice: machine word,
//                cache line width and the arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    // Architectural machine word
    typedef logic [31:0] rv32i_word;

    // Width of one cache line moved between caches and memory
    localparam int LINE_WIDTH = 256;

    typedef logic [LINE_WIDTH-1:0] line_t;

    // Arbiter FSM states: idle, serving the I-cache, serving the D-cache
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage : rv32i_types

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
//  Module      : cache_arbiter
//  Description : Arbitrates one outstanding line transaction between an
//                I-cache and a D-cache onto a single memory port. The granted
//                request's address, write flag and writeback line are latched
//                on grant, so requester changes mid-transaction are ignored.
//                Completion and read data are passed combinationally in the
//                pmem_resp cycle. Tie-break: D-cache wins by default; with
//                CACHE_ARBITER_RR_EN defined, ties alternate (first tie -> D).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_read,
    input  rv32i_word             i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  rv32i_word             d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output rv32i_word             pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t state;
    logic       d_req;
    logic       grant_d;

    assign d_req = d_read | d_write;

`ifdef CACHE_ARBITER_RR_EN
    // 1 when the most recent grant went to the D-cache; resets to I
    logic last_grant_d;

    // On a tie, grant whichever requester was not granted last
    assign grant_d = d_req & (~i_read | ~last_grant_d);

    // Remember the winner of every grant taken from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d <= 1'b0;
        end else if ((state == IDLE) && (d_req || i_read)) begin
            last_grant_d <= grant_d;
        end
    end
`else
    // Fixed priority: any D-cache request beats the I-cache
    assign grant_d = d_req;
`endif

    // Arbiter FSM with latched memory-side request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state        <= SERVE_D;
                        pmem_address <= d_address;
                        // Read and write together count as a writeback
                        pmem_write   <= d_write;
                        pmem_read    <= ~d_write;
                        pmem_wdata   <= d_write ? d_wdata : '0;
                    end else if (i_read) begin
                        state        <= SERVE_I;
                        pmem_address <= i_address;
                        pmem_write   <= 1'b0;
                        pmem_read    <= 1'b1;
                        pmem_wdata   <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Completion returns to IDLE, forcing one idle cycle
                    if (pmem_resp) begin
                        state        <= IDLE;
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        pmem_address <= '0;
                        pmem_wdata   <= '0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    pmem_read    <= 1'b0;
                    pmem_write   <= 1'b0;
                    pmem_address <= '0;
                    pmem_wdata   <= '0;
                end
            endcase
        end
    end

    // Responses are only issued while serving; a reset cycle abandons the
    // transaction so a coincident pmem_resp is not forwarded
    always_comb begin
        i_resp  = (state == SERVE_I) & pmem_resp & ~rst;
        d_resp  = (state == SERVE_D) & pmem_resp & ~rst;
        i_rdata = i_resp ? pmem_rdata : '0;
        d_rdata = d_resp ? pmem_rdata : '0;
    end

endmodule : cache_arbiter

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
//  Module      : tb_cache_arbiter
//  Description : Self-checking bench for cache_arbiter: a vector table for the
//                tie/back-to-back case, directed sequences for latching,
//                reset abandonment and round-robin ties (CACHE_ARBITER_RR_EN),
//                and random traffic compared against a transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_arbiter;
    import rv32i_types::*;

`ifdef CACHE_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_read;
    rv32i_word             i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;
    logic                  d_read;
    logic                  d_write;
    rv32i_word             d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;
    logic                  pmem_read;
    logic                  pmem_write;
    rv32i_word             pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    cache_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Transaction model: who owns the memory port and what was captured
    int                    m_owner = 0;   // 0 none, 1 I-cache, 2 D-cache
    int                    m_last  = 1;   // last granted requester
    rv32i_word             m_addr  = '0;
    bit                    m_write = 1'b0;
    logic [LINE_WIDTH-1:0] m_wdata = '0;

    task automatic chk(input string name, input logic [LINE_WIDTH-1:0] act,
                       input logic [LINE_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_WIDTH-1:0] rand_line();
        logic [LINE_WIDTH-1:0] r;
        for (int k = 0; k < LINE_WIDTH / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Apply the grant/complete rules to the inputs present at this edge
    task automatic model_update();
        bit dq, iq, pick_d;
        dq = d_read || d_write;
        iq = i_read;
        if (rst) begin
            m_owner = 0; m_last = 1; m_addr = '0; m_write = 1'b0; m_wdata = '0;
        end else if (m_owner == 0) begin
            if (dq || iq) begin
                if (dq && iq) pick_d = RR ? (m_last == 1) : 1'b1;
                else          pick_d = dq;
                if (pick_d) begin
                    m_owner = 2; m_last = 2; m_addr = d_address;
                    m_write = d_write;
                    m_wdata = d_write ? d_wdata : '0;
                end else begin
                    m_owner = 1; m_last = 1; m_addr = i_address;
                    m_write = 1'b0; m_wdata = '0;
                end
            end
        end else if (pmem_resp) begin
            m_owner = 0;
        end
    endtask

    task automatic check_model();
        bit exp_ir, exp_dr;
        exp_ir = (m_owner == 1) && pmem_resp && !rst;
        exp_dr = (m_owner == 2) && pmem_resp && !rst;
        chk("pmem_read",    pmem_read,    (m_owner != 0) && !m_write);
        chk("pmem_write",   pmem_write,   (m_owner != 0) && m_write);
        chk("pmem_address", pmem_address, (m_owner != 0) ? m_addr : '0);
        chk("pmem_wdata",   pmem_wdata,   (m_owner == 2 && m_write) ? m_wdata : '0);
        chk("i_resp",  i_resp,  exp_ir);
        chk("d_resp",  d_resp,  exp_dr);
        chk("i_rdata", i_rdata, exp_ir ? pmem_rdata : '0);
        chk("d_rdata", d_rdata, exp_dr ? pmem_rdata : '0);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    typedef struct {
        logic ir, dr, dw, pr;          // stimulus
        logic e_ir, e_dr, e_pr, e_pw;  // expected i_resp, d_resp, pmem_read, pmem_write
    } vec_t;

    function automatic vec_t mk(input logic ir, dr, dw, pr, e_ir, e_dr, e_pr, e_pw);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.pr = pr;
        v.e_ir = e_ir; v.e_dr = e_dr; v.e_pr = e_pr; v.e_pw = e_pw;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        rv32i_word rr_addr[4];
        bit i_pend, d_pend;
        int d_kind;

        rst = 1'b1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
        @(negedge clk);
        advance();
        advance();
        rst = 1'b0;
        #1;
        chk("reset pmem_read",    pmem_read,    '0);
        chk("reset pmem_write",   pmem_write,   '0);
        chk("reset pmem_address", pmem_address, '0);
        chk("reset pmem_wdata",   pmem_wdata,   '0);
        chk("reset i_resp",       i_resp,       '0);
        chk("reset d_resp",       d_resp,       '0);

        // Tie with fixed/first-tie priority to D, then I, spurious resp, write+read
        //           ir dr dw pr   eir edr epr epw
        tbl[0]  = mk(1, 1, 0, 0,   0,  0,  0,  0);
        tbl[1]  = mk(1, 1, 0, 0,   0,  0,  1,  0);
        tbl[2]  = mk(1, 1, 0, 1,   0,  1,  1,  0);
        tbl[3]  = mk(1, 0, 0, 0,   0,  0,  0,  0);
        tbl[4]  = mk(1, 0, 0, 0,   0,  0,  1,  0);
        tbl[5]  = mk(1, 0, 0, 1,   1,  0,  1,  0);
        tbl[6]  = mk(0, 0, 0, 1,   0,  0,  0,  0);
        tbl[7]  = mk(0, 1, 1, 0,   0,  0,  0,  0);
        tbl[8]  = mk(0, 1, 1, 0,   0,  0,  0,  1);
        tbl[9]  = mk(0, 1, 1, 1,   0,  1,  0,  1);
        tbl[10] = mk(0, 0, 0, 0,   0,  0,  0,  0);
        i_address = 32'h40; d_address = 32'h80; d_wdata = {8{32'h5A5A_0000}};
        for (int k = 0; k < 11; k++) begin
            i_read = tbl[k].ir; d_read = tbl[k].dr; d_write = tbl[k].dw;
            pmem_resp = tbl[k].pr; pmem_rdata = {8{32'hC0DE_0000 + k}};
            #1;
            chk($sformatf("tbl%0d i_resp", k),     i_resp,     tbl[k].e_ir);
            chk($sformatf("tbl%0d d_resp", k),     d_resp,     tbl[k].e_dr);
            chk($sformatf("tbl%0d pmem_read", k),  pmem_read,  tbl[k].e_pr);
            chk($sformatf("tbl%0d pmem_write", k), pmem_write, tbl[k].e_pw);
            chk($sformatf("tbl%0d i_rdata", k), i_rdata, tbl[k].e_ir ? pmem_rdata : '0);
            chk($sformatf("tbl%0d d_rdata", k), d_rdata, tbl[k].e_dr ? pmem_rdata : '0);
            advance();
        end
        i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;

        // I-cache read with memory answering three cycles after the request
        i_read = 1; i_address = 32'h0000_0060;
        #1; chk("ird idle pmem_read", pmem_read, '0);
        advance();
        chk("ird T+1 pmem_read", pmem_read, 1'b1);
        chk("ird T+1 address", pmem_address, 32'h60);
        advance(); advance();
        chk("ird wait i_resp", i_resp, '0);
        pmem_resp = 1; pmem_rdata = {32{8'hAA}};
        #1;
        chk("ird i_resp", i_resp, 1'b1);
        chk("ird i_rdata", i_rdata, {32{8'hAA}});
        chk("ird d_resp", d_resp, '0);
        advance();
        i_read = 0; pmem_resp = 0;
        #1; chk("ird after pmem_read", pmem_read, '0);
        advance();

        // D-cache writeback with the address changing mid-transaction
        d_write = 1; d_address = 32'h0000_1000; d_wdata = {8{32'h1234_5678}};
        advance();
        chk("dwr pmem_write", pmem_write, 1'b1);
        chk("dwr pmem_read", pmem_read, '0);
        chk("dwr wdata", pmem_wdata, {8{32'h1234_5678}});
        d_address = 32'hDEAD_0000; d_wdata = '1;
        advance();
        chk("dwr address held", pmem_address, 32'h1000);
        chk("dwr wdata held", pmem_wdata, {8{32'h1234_5678}});
        pmem_resp = 1; pmem_rdata = rand_line();
        #1; chk("dwr d_resp", d_resp, 1'b1);
        advance();
        d_write = 0; pmem_resp = 0;
        #1; chk("dwr single d_resp", d_resp, '0);
        advance();

        // Reset during SERVE_D abandons the transaction
        d_read = 1; d_address = 32'h0000_2000;
        advance();
        chk("rst serve pmem_read", pmem_read, 1'b1);
        rst = 1; d_read = 0;
        advance();
        rst = 0; pmem_resp = 1; pmem_rdata = rand_line();
        #1;
        chk("rst pmem_read dropped", pmem_read, '0);
        chk("rst no d_resp", d_resp, '0);
        chk("rst d_rdata zero", d_rdata, '0);
        advance();
        pmem_resp = 0; i_read = 1; i_address = 32'h0000_0080;
        advance();
        chk("post-rst pmem_address", pmem_address, 32'h80);
        pmem_resp = 1; pmem_rdata = rand_line();
        #1; chk("post-rst i_resp", i_resp, 1'b1);
        advance();
        i_read = 0; pmem_resp = 0;
        advance();

`ifdef CACHE_ARBITER_RR_EN
        // Four back-to-back ties alternate D, I, D, I
        rr_addr[0] = 32'h200; rr_addr[1] = 32'h100;
        rr_addr[2] = 32'h200; rr_addr[3] = 32'h100;
        i_read = 1; d_read = 1; i_address = 32'h100; d_address = 32'h200;
        for (int k = 0; k < 4; k++) begin
            advance();
            chk($sformatf("rr tie%0d grant", k), pmem_address, rr_addr[k]);
            pmem_resp = 1; pmem_rdata = rand_line();
            advance();
            pmem_resp = 0;
        end
        i_read = 0; d_read = 0;
        advance();
`else
        rr_addr[0] = '0;
        rr_addr[1] = '0;
        rr_addr[2] = '0;
        rr_addr[3] = '0;
`endif

        // Random traffic against the transaction model
        i_pend = 0; d_pend = 0; d_kind = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_address = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                i_address = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_kind = $urandom_range(0, 2);
                d_address = $urandom; d_wdata = rand_line();
            end else if ($urandom_range(0, 3) == 0) begin
                d_address = $urandom; d_wdata = rand_line();
            end
            i_read  = i_pend;
            d_read  = d_pend && (d_kind != 1);
            d_write = d_pend && (d_kind != 0);
            pmem_resp  = ($urandom_range(0, 2) == 0);
            pmem_rdata = rand_line();
            #1;
            check_model();
            if (i_resp) i_pend = 0;
            if (d_resp) d_pend = 0;
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cache_arbiter

`default_nettype wire

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports are clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 i_read  input  1  I-cache line read request; held high until i_resp.
REQ-005 i_address  input  32  I-cache line address (rv32i_word).
REQ-006 i_rdata  output  256  line returned to the I-cache.
REQ-007 i_resp  output  1  one-cycle completion strobe to the I-cache.
REQ-008 d_read / d_write  input  1 each  D-cache line read or writeback request; held until d_resp.
REQ-009 d_address  input  32  D-cache line address.
REQ-010 d_wdata  input  256  D-cache writeback line.
REQ-011 d_rdata  output  256  line returned to the D-cache.
REQ-012 d_resp  output  1  one-cycle completion strobe to the D-cache.
REQ-013 pmem_read / pmem_write  output  1 each  memory-side request, held until pmem_resp.
REQ-014 pmem_address  output  32  latched address of the granted requester.
REQ-015 pmem_wdata  output  256  latched D-cache writeback line.
REQ-016 pmem_rdata  input  256  line from memory, valid with pmem_resp.
REQ-017 pmem_resp  input  1  memory completion strobe.

Function
REQ-018 The FSM SHALL have the states IDLE, SERVE_I and SERVE_D; at most one transaction is outstanding.
REQ-019 In IDLE, all outputs SHALL be 0 and the block samples requests; with any request pending, it SHALL grant one, latch address (and d_wdata, and a read/write flag), and enter SERVE_x on the next edge.
REQ-020 In SERVE_x, pmem_read or pmem_write SHALL be driven from the latched values only; requester input changes SHALL be ignored.
REQ-021 In the cycle pmem_resp=1, the granted requester's x_resp SHALL be 1 and x_rdata SHALL equal pmem_rdata combinationally; the FSM SHALL then return to IDLE.
REQ-022 Latency: request seen in IDLE at cycle T -> pmem request asserted at T+1 -> x_resp in the same cycle as pmem_resp.
REQ-023 At least one IDLE cycle SHALL separate back-to-back transactions.
REQ-024 If d_read and d_write are both high, the request SHALL be treated as a write.
REQ-025 Tie, fixed priority: the D-cache SHALL win.
REQ-026 x_rdata SHALL be 0 whenever x_resp=0.
REQ-027 The non-granted requester SHALL stay pending with no response until it is granted in a later IDLE cycle.
REQ-028 pmem_resp received while in IDLE SHALL be ignored.

Reset
REQ-029 rst SHALL force IDLE, clear the latched address, data and flag, and set last_grant to I. All outputs SHALL read 0 in the cycle after rst.
REQ-030 A reset during SERVE_x SHALL abandon the transaction: pmem_read/pmem_write drop, and no x_resp is issued for it.

Configuration
REQ-031 The macro CACHE_ARBITER_RR_EN SHALL select the tie-break policy.
REQ-032 When CACHE_ARBITER_RR_EN is defined, a tie SHALL grant the requester that was not last granted. last_grant updates on each grant and resets to I, so the first tie goes to D.
REQ-033 When CACHE_ARBITER_RR_EN is not defined, REQ-025 applies and no last_grant register is built.

Structure
REQ-034 The arbiter state enum arb_state_t SHALL be placed in the shared package rv32i_types, alongside rv32i_word. The 256-bit line width SHALL be a package constant.
REQ-035 No sub-module is needed: a single FSM module with latching registers and an output mux.

Verification
REQ-036 i_read=1, i_address=0x0000_0060; memory responds 3 cycles later with rdata=0xAA..AA -> pmem_read at T+1, pmem_address=0x60, i_resp with i_rdata=0xAA..AA, d_resp stays 0.
REQ-037 d_write=1, address 0x0000_1000, wdata=0x1234..; d_address changes mid-transaction -> pmem_write=1, pmem_address stays 0x1000, pmem_wdata=0x1234.., d_resp once.
REQ-038 i_read and d_read rise in the same cycle (fixed priority) -> D served first, then one IDLE cycle, then I served; i_resp never precedes d_resp.
REQ-039 With CACHE_ARBITER_RR_EN: four consecutive ties -> grants in order D, I, D, I.
REQ-040 Reset asserted in SERVE_D, then pmem_resp pulses -> pmem_read=0 after reset, no d_resp, FSM in IDLE; a subsequent i_read completes normally.
